// File: rtl/rca4_adder.sv
// rca4_adder: WIDTH-bit ripple-carry adder built from explicit full-adder cells.
// The combinational {cout, sum} can be chained cout->cin across instances to
// build wider adders. A registered copy with a one-cycle valid flag is provided
// for pipelined use.
// Optional feature macro: RCA4_OVF_EN adds signed-overflow outputs ovf/ovf_q.
module rca4_adder #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
`ifdef RCA4_OVF_EN
   output logic             ovf,
   output logic             ovf_q,
`endif
   output logic             valid_q
);

   // Carry chain: w_c[0] is the carry-in, w_c[WIDTH] the carry-out.
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_s;

   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_valid;

   assign w_c[0] = cin;

   // One full-adder cell per bit; the carry ripples LSB to MSB.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign w_s[i]   = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
   end

   assign sum  = w_s;
   assign cout = w_c[WIDTH];

   // Result capture: load on in_valid, otherwise hold data and drop valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_sum  <= w_s;
            r_cout <= w_c[WIDTH];
         end
      end
   end

   assign sum_q   = r_sum;
   assign cout_q  = r_cout;
   assign valid_q = r_valid;

`ifdef RCA4_OVF_EN
   logic w_ovf;
   logic r_ovf;

   // Two's-complement overflow: carry into and out of the sign bit disagree.
   assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];
   assign ovf   = w_ovf;

   // Overflow capture follows the same load/hold/reset rules as cout_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (in_valid) begin
         r_ovf <= w_ovf;
      end
   end

   assign ovf_q = r_ovf;
`endif

endmodule

// File: tb/tb_rca4_adder.sv
// Self-checking bench for rca4_adder: arithmetic reference model, per-cycle
// compare process, directed literal checks and a 16-bit chained configuration.
module tb_rca4_adder;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a, b;
   logic         cin;
   logic         in_valid;
   logic [W-1:0] sum, sum_q;
   logic         cout, cout_q, valid_q;
`ifdef RCA4_OVF_EN
   logic         ovf, ovf_q;
`endif

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   rca4_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
      .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q),
`ifdef RCA4_OVF_EN
      .ovf(ovf), .ovf_q(ovf_q),
`endif
      .valid_q(valid_q)
   );

   // 16-bit adder from four chained instances.
   logic [15:0] ch_a, ch_b, ch_sum;
   logic        ch_cin;
   logic [4:0]  ch_c;
   logic [15:0] ch_sum_q;
   logic [3:0]  ch_cout_q, ch_valid_q;
`ifdef RCA4_OVF_EN
   logic [3:0]  ch_ovf, ch_ovf_q;
`endif
   assign ch_c[0] = ch_cin;

   for (genvar k = 0; k < 4; k++) begin : g_chain
      rca4_adder #(.WIDTH(4)) u_seg (
         .clk(clk), .rst_n(rst_n),
         .a(ch_a[4*k +: 4]), .b(ch_b[4*k +: 4]), .cin(ch_c[k]), .in_valid(1'b0),
         .sum(ch_sum[4*k +: 4]), .cout(ch_c[k+1]),
         .sum_q(ch_sum_q[4*k +: 4]), .cout_q(ch_cout_q[k]),
`ifdef RCA4_OVF_EN
         .ovf(ch_ovf[k]), .ovf_q(ch_ovf_q[k]),
`endif
         .valid_q(ch_valid_q[k])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: plain integer arithmetic plus a one-deep result store.
   int m_q_res;
   logic m_q_valid;
   int m_q_ovf;

   function automatic int model_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic c);
      return int'(x) + int'(y) + int'(c);
   endfunction

   function automatic int model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic c);
      int sx, sy, s;
      sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
      sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
      s  = sx + sy + int'(c);
      return (s > (1 << (W-1)) - 1 || s < -(1 << (W-1))) ? 1 : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q_res   <= 0;
         m_q_valid <= 1'b0;
         m_q_ovf   <= 0;
      end else begin
         m_q_valid <= in_valid;
         if (in_valid) begin
            m_q_res <= model_res(a, b, cin);
            m_q_ovf <= model_ovf(a, b, cin);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("comb_result", int'({cout, sum}), model_res(a, b, cin));
         check("reg_result", int'({cout_q, sum_q}), m_q_res);
         check("reg_valid", int'(valid_q), int'(m_q_valid));
`ifdef RCA4_OVF_EN
         check("comb_ovf", int'(ovf), model_ovf(a, b, cin));
         check("reg_ovf", int'(ovf_q), m_q_ovf);
`endif
      end
   end

   task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic v);
      @(posedge clk);
      #1;
      a = x; b = y; cin = c; in_valid = v;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
      ch_a = '0; ch_b = '0; ch_cin = 1'b0;
      #1;
      check("reset_sum_q", int'(sum_q), 0);
      check("reset_cout_q", int'(cout_q), 0);
      check("reset_valid_q", int'(valid_q), 0);
      #12 rst_n = 1'b1;
      chk_en = 1'b1;

      // F + 1 + 0 wraps to 0 with carry; captured one cycle later.
      drive(4'hF, 4'h1, 1'b0, 1'b1);
      settle();
      check("f_plus_1_sum", int'(sum), 0);
      check("f_plus_1_cout", int'(cout), 1);
      drive(4'h5, 4'h3, 1'b1, 1'b0);
      settle();
      check("f_plus_1_sum_q", int'(sum_q), 0);
      check("f_plus_1_cout_q", int'(cout_q), 1);
      check("f_plus_1_valid_q", int'(valid_q), 1);
      check("5_3_1_sum", int'(sum), 9);
      check("5_3_1_cout", int'(cout), 0);
`ifdef RCA4_OVF_EN
      check("5_3_1_ovf", int'(ovf), 1);
`endif
      // Held data, dropped valid.
      drive(4'hF, 4'hF, 1'b1, 1'b0);
      settle();
      check("hold_valid_q", int'(valid_q), 0);
      check("hold_sum_q", int'(sum_q), 0);
      check("wrap_sum", int'(sum), 15);
      check("wrap_cout", int'(cout), 1);
      drive(4'h0, 4'h0, 1'b0, 1'b0);
      settle();
      check("zero_sum", int'(sum), 0);
      check("zero_cout", int'(cout), 0);

      // Exhaustive sweep with back-to-back captures.
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v = 9'(i);
         drive(v[3:0], v[7:4], v[8], 1'b1);
      end
      // Random vectors with random qualification.
      for (int i = 0; i < 50; i++) begin
         drive(4'($urandom_range(15)), 4'($urandom_range(15)),
               1'($urandom_range(1)), 1'($urandom_range(1)));
      end

      // Asynchronous reset in the middle of a cycle discards the capture.
      drive(4'h5, 4'h3, 1'b1, 1'b1);
      drive(4'h2, 4'h2, 1'b0, 1'b0);
      #1;
      check("pre_reset_sum_q", int'(sum_q), 9);
      check("pre_reset_valid_q", int'(valid_q), 1);
      rst_n = 1'b0;
      #1;
      check("async_sum_q", int'(sum_q), 0);
      check("async_cout_q", int'(cout_q), 0);
      check("async_valid_q", int'(valid_q), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      settle();
      settle();
      check("post_reset_valid_q", int'(valid_q), 0);
      check("post_reset_sum_q", int'(sum_q), 0);

      // Chained 16-bit adder.
      ch_a = 16'hFFFF; ch_b = 16'h0001; ch_cin = 1'b0;
      #1;
      check("chain_ffff_1", int'({ch_c[4], ch_sum}), 32'h10000);
      ch_a = 16'h1234; ch_b = 16'hABCD; ch_cin = 1'b1;
      #1;
      check("chain_1234_abcd", int'({ch_c[4], ch_sum}), 32'h0BE02);
      for (int i = 0; i < 8; i++) begin
         ch_a = 16'($urandom); ch_b = 16'($urandom); ch_cin = 1'($urandom_range(1));
         #1;
         check("chain_rand", int'({ch_c[4], ch_sum}),
               int'(ch_a) + int'(ch_b) + int'(ch_cin));
      end

      settle();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
